mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameters: ADDR_W, default 64, byte address width; DATA_W, default 64, data width; BE_W, default DATA_W/8, byte-enable width.
REQ-002 The block SHALL have ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  single clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction-fetch request, held until i_gnt.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch request accepted.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request, held until d_gnt.
- d_we  in  1  data write enable.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_be  in  BE_W  byte enables.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  data response (read data, or write done).
- d_rdata  out  DATA_W  data read data.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  BE_W  memory byte enables.
- mem_gnt  in  1  memory accepts request.
- mem_rvalid  in  1  memory response valid.
- mem_rdata  in  DATA_W  memory read data.

Function
REQ-003 The block SHALL use three states: IDLE, ISSUE and WAIT. It SHALL allow exactly one outstanding memory transaction.
REQ-004 In IDLE with any request, the block SHALL select one winner, pulse that requester's gnt combinationally for one cycle, register its command, and go to ISSUE.
REQ-005 Instruction fetches SHALL issue with mem_we=0 and mem_be all ones.
REQ-006 mem_req SHALL assert on the cycle after the grant, and it and the command fields SHALL remain stable until mem_gnt is sampled high. The block SHALL then go to WAIT.
REQ-007 In WAIT, on mem_rvalid the block SHALL pulse the owner's rvalid for exactly one cycle, with rdata equal to mem_rdata in that same cycle, and SHALL return to IDLE.
REQ-008 The non-owner's rvalid SHALL stay 0 throughout the transaction.
REQ-009 Minimum request-to-response latency SHALL be 2 cycles plus memory latency. At least one IDLE cycle SHALL separate consecutive transactions.
REQ-010 mem_rvalid in IDLE or ISSUE SHALL be ignored.
REQ-011 mem_gnt outside ISSUE SHALL be ignored.
REQ-012 A request that arrives while the block is busy SHALL wait and never be dropped.
REQ-013 With i_req and d_req both high in IDLE, the winner SHALL be the one given in REQ-018.
REQ-014 i_rdata and d_rdata SHALL be 0 whenever the corresponding rvalid is 0.

Reset
REQ-015 While rst is high, the state SHALL be IDLE.
REQ-016 While rst is high, all outputs SHALL be 0, the registered command SHALL be cleared, and the last-owner flag SHALL be DATA.
REQ-017 A reset during ISSUE or WAIT SHALL abandon the transaction. A late mem_rvalid after reset SHALL produce no rvalid pulse.

Configuration
REQ-018 Macro MEM_ARB_RR_EN selects the arbitration policy:
- Defined: round-robin. On a tie, the requester not granted last wins, so the first tie after reset goes to fetch. The last-owner flag updates on each grant.
- Undefined: fixed priority, data always wins a tie. The last-owner flag is unused.

Structure
REQ-019 Shared package raisin64_mem_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT), the owner enum (FETCH/DATA), and default width constants.
REQ-020 One sub-module, arb_pick, SHALL compute the winner from i_req, d_req and the last owner. It SHALL be purely combinational and is the only code affected by MEM_ARB_RR_EN.

Verification
REQ-021 Reset, then i_req with i_addr=0x100; memory gives mem_gnt at once and mem_rvalid 2 cycles later with rdata=0xDEADBEEF -> i_gnt at cycle 0, mem_req at cycle 1, i_rvalid=1 with i_rdata=0xDEADBEEF at cycle 4, d_rvalid stays 0.
REQ-022 d_req write, d_addr=0x2000, d_wdata=0x55, d_be=0x01, mem_gnt held low 3 cycles -> mem_req and fields stable for 4 cycles, then a single d_rvalid pulse.
REQ-023 i_req and d_req both high for 4 transactions -> without the macro: D,D,D,D (fetch starves while d_req stays high). With MEM_ARB_RR_EN: I,D,I,D.
REQ-024 Assert rst in WAIT, deassert, then drive mem_rvalid=1 -> no rvalid pulse, state IDLE, all outputs 0.
REQ-025 Drive mem_rvalid and mem_gnt in IDLE with no requests -> no outputs change.

Source files
------------

// File: rtl/raisin64_mem_pkg.sv
// Shared types and default widths for the raisin64 memory arbiter.
// Holds the arbiter state enum, the transaction owner enum and the
// default address/data widths used by mem_arbiter.
package raisin64_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 64;
    localparam int unsigned DEF_DATA_W = 64;

    // Arbiter sequencing: accept a request, present it to memory, await response.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Which requester owns the current (or most recent) transaction.
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: purely combinational winner selection between the instruction
// fetch port and the data port.
// Build option: MEM_ARB_RR_EN selects round-robin on a tie (the requester
// not granted last wins); without it, data always wins a tie.
// Ports:
//   i_req, d_req  - pending requests from fetch and data ports
//   last          - owner of the most recent grant
//   valid         - at least one request is pending
//   win           - selected owner (meaningful only when valid)
module arb_pick
    import raisin64_mem_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last,
    output logic   valid,
    output owner_t win
);

`ifdef MEM_ARB_RR_EN
    // Round-robin: on a tie, hand the grant to whoever did not have it last.
    always_comb begin
        valid = i_req | d_req;
        win   = DATA;
        if (i_req && d_req) begin
            win = (last == DATA) ? FETCH : DATA;
        end else if (i_req) begin
            win = FETCH;
        end
    end
`else
    // Fixed priority: data wins any tie; the history input has no role.
    logic unused_last;
    assign unused_last = (last == DATA);

    always_comb begin
        valid = i_req | d_req;
        win   = DATA;
        if (i_req && !d_req) begin
            win = FETCH;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-outstanding memory port between an
// instruction-fetch requester and a data requester.
// Build option: MEM_ARB_RR_EN (round-robin tie-break, see arb_pick).
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   i_req/i_addr             - fetch request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata   - fetch accept pulse and read response
//   d_req/d_we/d_addr/d_wdata/d_be - data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata   - data accept pulse and response
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be - registered memory command
//   mem_gnt/mem_rvalid/mem_rdata             - memory handshake and response
// Grants and responses are combinational pulses; the memory command is
// registered and held stable until memory accepts it.
module mem_arbiter
    import raisin64_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state;
    owner_t owner;
    owner_t last_owner;
    logic   pick_valid;
    owner_t pick_win;
    logic   grant;

    arb_pick u_arb_pick (
        .i_req (i_req),
        .d_req (d_req),
        .last  (last_owner),
        .valid (pick_valid),
        .win   (pick_win)
    );

    // Grant pulse: only from IDLE, and never while reset is held.
    always_comb begin
        grant = 1'b0;
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst && state == IDLE && pick_valid) begin
            grant = 1'b1;
            i_gnt = (pick_win == FETCH);
            d_gnt = (pick_win == DATA);
        end
    end

    // Response steering: only the owner sees rvalid, and rdata is zero otherwise.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if (!rst && state == WAIT && mem_rvalid) begin
            if (owner == FETCH) begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
            end else begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
        end
    end

    // Sequencer and registered memory command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= DATA;
            last_owner <= DATA;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner      <= pick_win;
                        last_owner <= pick_win;
                        mem_req    <= 1'b1;
                        state      <= ISSUE;
                        if (pick_win == FETCH) begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_be    <= {BE_W{1'b1}};
                        end else begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors with hand-computed
// expectations. Inputs change just after the falling edge and outputs are
// sampled 1 time unit later, well away from the rising edge.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BE_W   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    // Expected tie-break sequence (1 = data wins) and first tie after reset.
`ifdef MEM_ARB_RR_EN
    logic exp_d [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_first_d = 1'b0;
`else
    logic exp_d [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic exp_first_d = 1'b1;
`endif

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BE_W   (BE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_gnt"},     64'(i_gnt),     64'h0);
        check({tag, "_d_gnt"},     64'(d_gnt),     64'h0);
        check({tag, "_i_rvalid"},  64'(i_rvalid),  64'h0);
        check({tag, "_d_rvalid"},  64'(d_rvalid),  64'h0);
        check({tag, "_i_rdata"},   i_rdata,        64'h0);
        check({tag, "_d_rdata"},   d_rdata,        64'h0);
        check({tag, "_mem_req"},   64'(mem_req),   64'h0);
        check({tag, "_mem_we"},    64'(mem_we),    64'h0);
        check({tag, "_mem_addr"},  mem_addr,       64'h0);
        check({tag, "_mem_wdata"}, mem_wdata,      64'h0);
        check({tag, "_mem_be"},    64'(mem_be),    64'h0);
    endtask

    initial begin
        rst        = 1'b1;
        i_req      = 1'b1;
        i_addr     = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_be       = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset: everything quiet even with a pending request.
        @(negedge clk); #1;
        check_all_zero("rst");
        @(negedge clk);
        rst   = 1'b0;
        i_req = 1'b0;

        // Fetch read, memory accepts immediately.
        @(negedge clk);
        i_req = 1'b1; i_addr = 64'h100; mem_gnt = 1'b1;
        #1;
        check("t1_i_gnt",   64'(i_gnt),   64'h1);
        check("t1_d_gnt",   64'(d_gnt),   64'h0);
        check("t1_req_c0",  64'(mem_req), 64'h0);
        @(negedge clk);
        i_req = 1'b0; i_addr = '0;
        #1;
        check("t1_req_c1",  64'(mem_req), 64'h1);
        check("t1_addr",    mem_addr,     64'h100);
        check("t1_we",      64'(mem_we),  64'h0);
        check("t1_be",      64'(mem_be),  64'hff);
        check("t1_gnt_c1",  64'(i_gnt),   64'h0);
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("t1_req_c2",  64'(mem_req),  64'h0);
        check("t1_rv_c2",   64'(i_rvalid), 64'h0);
        @(negedge clk); #1;
        check("t1_rv_c3",   64'(i_rvalid), 64'h0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'hDEADBEEF;
        #1;
        check("t1_rv_c4",   64'(i_rvalid), 64'h1);
        check("t1_rdata",   i_rdata,       64'hDEADBEEF);
        check("t1_d_rv",    64'(d_rvalid), 64'h0);
        check("t1_d_rdata", d_rdata,       64'h0);
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        check("t1_rv_c5",   64'(i_rvalid), 64'h1 ^ 64'h1);
        check("t1_rdata_c5", i_rdata,      64'h0);

        // Data write with memory stalling three cycles.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2000; d_wdata = 64'h55; d_be = 8'h01;
        #1;
        check("t2_d_gnt", 64'(d_gnt), 64'h1);
        check("t2_i_gnt", 64'(i_gnt), 64'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
            mem_gnt = (k == 4);
            #1;
            check("t2_req",   64'(mem_req),  64'h1);
            check("t2_we",    64'(mem_we),   64'h1);
            check("t2_addr",  mem_addr,      64'h2000);
            check("t2_wdata", mem_wdata,     64'h55);
            check("t2_be",    64'(mem_be),   64'h01);
            check("t2_rv",    64'(d_rvalid), 64'h0);
        end
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("t2_req_done", 64'(mem_req),  64'h0);
        check("t2_rv_wait",  64'(d_rvalid), 64'h0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        #1;
        check("t2_rv_pulse", 64'(d_rvalid), 64'h1);
        check("t2_rdata",    d_rdata,       64'h1234);
        check("t2_i_rv",     64'(i_rvalid), 64'h0);
        check("t2_i_rdata",  i_rdata,       64'h0);
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        check("t2_rv_single", 64'(d_rvalid), 64'h0);

        // Both requesters held high across four transactions.
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b1; i_addr = 64'h300; d_addr = 64'h400;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h77;
        #1;
        for (int t = 0; t < 4; t++) begin
            check("t3_d_gnt", 64'(d_gnt), 64'(exp_d[t]));
            check("t3_i_gnt", 64'(i_gnt), 64'(!exp_d[t]));
            @(negedge clk); #1;
            check("t3_issue_rv", 64'(i_rvalid | d_rvalid), 64'h0);
            @(negedge clk); #1;
            check("t3_d_rv", 64'(d_rvalid), 64'(exp_d[t]));
            check("t3_i_rv", 64'(i_rvalid), 64'(!exp_d[t]));
            @(negedge clk);
            if (t == 3) begin
                i_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            end
            #1;
        end
        i_addr = '0;
        d_addr = '0;

        // Reset while waiting on memory; a late response must be dropped.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
        #1;
        check("t4_d_gnt", 64'(d_gnt), 64'h1);
        @(negedge clk);
        d_req = 1'b0; d_addr = '0; mem_gnt = 1'b1;
        #1;
        check("t4_req", 64'(mem_req), 64'h1);
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("t4_wait_req", 64'(mem_req), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("t4_rst");
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hAA;
        #1;
        check_all_zero("t4_late");
        @(negedge clk); #1;
        check_all_zero("t4_late2");

        // Stray memory handshakes in IDLE with no requests.
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        check_all_zero("t5");
        @(negedge clk); #1;
        check_all_zero("t5b");

        // First tie after reset.
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h99;
        i_req = 1'b1; d_req = 1'b1; i_addr = 64'h500; d_addr = 64'h600;
        #1;
        check("t6_d_gnt", 64'(d_gnt), 64'(exp_first_d));
        check("t6_i_gnt", 64'(i_gnt), 64'(!exp_first_d));
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b1;
        #1;
        check("t6_addr", mem_addr, exp_first_d ? 64'h600 : 64'h500);
        check("t6_be",   64'(mem_be), exp_first_d ? 64'h00 : 64'hff);
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        #1;
        check("t6_d_rv", 64'(d_rvalid), 64'(exp_first_d));
        check("t6_i_rv", 64'(i_rvalid), 64'(!exp_first_d));
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("t6_rv_end", 64'(i_rvalid | d_rvalid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
